// File: rtl/mem_master_pkg.sv
// mem_master_pkg: FSM state type and default width constants shared by mem_master.
// Macro MEM_MASTER_VERIFY_EN adds the CHK state used by write readback.
package mem_master_pkg;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_RD_LAT     = 1;
`ifdef MEM_MASTER_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WAIT, S_CHK} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_WAIT} state_e;
`endif
endpackage

// File: rtl/mem_master_fifo.sv
// mem_master_fifo: command FIFO, DEPTH entries (power of two), show-ahead read.
// Ports: clk, rst_n (async active-low); push/wdata write side; pop/rdata head side;
// full, empty status derived from registered pointers only.
module mem_master_fifo
    import mem_master_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int W     = 1 + DEF_ADDR_W + DEF_DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q, rp_q;
    logic         do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= wdata;
    end
    // Extra pointer bit distinguishes full from empty; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_q + {{AW{1'b0}}, do_push};
            rp_q <= rp_q + {{AW{1'b0}}, do_pop};
        end
    end
    assign empty = wp_q == rp_q;
    assign full  = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
    assign rdata = mem_q[rp_q[AW-1:0]];
endmodule

// File: rtl/mem_master.sv
// mem_master: queues read/write commands and executes them against a simple memory slave.
// Ports: clk, rst_n (async active-low); cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata command
// input; rsp_valid/rsp_addr/rsp_rdata read response; busy; mem_addr/mem_data_in/mem_data_out/
// mem_read/mem_write memory side; err_cnt readback mismatch count.
// Macro MEM_MASTER_VERIFY_EN: each write is followed by a readback compare (RD, WAIT, CHK).
module mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int RD_LAT     = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_read,
    output logic              mem_write,
    output logic [7:0]        err_cnt
);
    localparam int CMD_W = 1 + ADDR_W + DATA_W;
    logic [CMD_W-1:0]  head;
    logic              full, empty, push, pop;
    logic              h_write;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    state_e            state_q;
    logic [2:0]        cnt_q;
    logic [DATA_W-1:0] sample_q;
    logic              mem_read_q, mem_write_q, rsp_valid_q;
    logic [ADDR_W-1:0] mem_addr_q, rsp_addr_q;
    logic [DATA_W-1:0] mem_data_in_q, rsp_rdata_q;
    logic              wait_end, rsp_fire, done;
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    mem_master_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({cmd_write, cmd_addr, cmd_wdata}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );
    assign h_write  = head[CMD_W-1];
    assign h_addr   = head[DATA_W +: ADDR_W];
    assign h_data   = head[DATA_W-1:0];
    // WAIT spans RD_LAT+1 cycles: data is captured on its RD_LAT-th edge, the response is issued on the last.
    assign wait_end = state_q == S_WAIT && cnt_q == 3'(RD_LAT);
`ifdef MEM_MASTER_VERIFY_EN
    logic       rb_q;
    logic [7:0] err_q;
    assign rsp_fire = wait_end && !rb_q;
    assign done     = state_q == S_IDLE || state_q == S_CHK || rsp_fire;
    assign err_cnt  = err_q;
`else
    assign rsp_fire = wait_end;
    assign done     = state_q == S_IDLE || state_q == S_WR || rsp_fire;
    assign err_cnt  = 8'd0;
`endif
    // done marks the edge where the current operation retires and the next head may launch.
    assign pop = done && !empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            sample_q      <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_rdata_q   <= '0;
`ifdef MEM_MASTER_VERIFY_EN
            rb_q          <= 1'b0;
            err_q         <= 8'd0;
`endif
        end else begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            cnt_q       <= cnt_q + 3'd1;
            if (state_q == S_RD) begin
                state_q <= S_WAIT;
                cnt_q   <= '0;
            end
            if (state_q == S_WAIT && cnt_q == 3'(RD_LAT - 1)) sample_q <= mem_data_out;
            if (rsp_fire) begin
                rsp_valid_q <= 1'b1;
                rsp_addr_q  <= mem_addr_q;
                rsp_rdata_q <= sample_q;
            end
`ifdef MEM_MASTER_VERIFY_EN
            // Readback reuses the held write address; the held write data is the reference.
            if (state_q == S_WR) begin
                state_q    <= S_RD;
                mem_read_q <= 1'b1;
                rb_q       <= 1'b1;
            end
            if (wait_end && rb_q) state_q <= S_CHK;
            if (state_q == S_CHK && sample_q != mem_data_in_q && err_q != 8'hFF) err_q <= err_q + 8'd1;
`endif
            if (done) begin
                state_q <= S_IDLE;
                if (!empty) begin
                    state_q     <= h_write ? S_WR : S_RD;
                    mem_write_q <= h_write;
                    mem_read_q  <= !h_write;
                    mem_addr_q  <= h_addr;
                    if (h_write) mem_data_in_q <= h_data;
`ifdef MEM_MASTER_VERIFY_EN
                    rb_q        <= 1'b0;
`endif
                end
            end
        end
    end
    assign busy        = !empty || state_q != S_IDLE;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_addr    = rsp_addr_q;
    assign rsp_rdata   = rsp_rdata_q;
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: scoreboard bench for mem_master (RD_LAT=1 main instance, RD_LAT=3 latency instance).
module tb_mem_master;
    localparam int LAT1  = 1;
    localparam int DEPTH = 4;

    typedef struct {
        bit          wr;
        bit          rb;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_write, rsp_valid, busy, mem_read, mem_write;
    logic [15:0] cmd_addr, rsp_addr, mem_addr;
    logic [7:0]  cmd_wdata, rsp_rdata, mem_data_in, mem_data_out, err_cnt;
    logic        cmd_valid3, cmd_ready3, cmd_write3, rsp_valid3, busy3, mem_read3, mem_write3;
    logic [15:0] cmd_addr3, rsp_addr3, mem_addr3;
    logic [7:0]  cmd_wdata3, rsp_rdata3, mem_data_in3, mem_data_out3, err_cnt3;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    int exp_err = 0;
    bit mon_en = 0;
    bit saw_full = 0;
    bit corrupt_en = 0;
    ev_t exp_mem[$];
    ev_t exp_rsp[$];
    int  lat_q[$];
    int  wr_cyc[$];
    logic [7:0] rmem [bit [15:0]];
    logic [7:0] smem [bit [15:0]];
    logic [7:0] smem3 [bit [15:0]];
    logic [7:0] rd1, p30, p31, p32;
    int ov3 = 0, n_rsp3 = 0, rd3_cyc = 0, lat3 = 0;
    logic [15:0] wa3 = '0, ra3 = '0;
    logic [7:0]  wd3 = '0, rdv3 = '0;

    mem_master #(.ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(DEPTH), .RD_LAT(LAT1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_read(mem_read), .mem_write(mem_write), .err_cnt(err_cnt)
    );
    mem_master #(.ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(DEPTH), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_write(cmd_write3), .cmd_addr(cmd_addr3), .cmd_wdata(cmd_wdata3),
        .rsp_valid(rsp_valid3), .rsp_addr(rsp_addr3), .rsp_rdata(rsp_rdata3), .busy(busy3),
        .mem_addr(mem_addr3), .mem_data_in(mem_data_in3), .mem_data_out(mem_data_out3),
        .mem_read(mem_read3), .mem_write(mem_write3), .err_cnt(err_cnt3)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Memory slaves: writes land at the strobe edge, read data is valid for exactly one cycle RD_LAT after the strobe.
    always @(posedge clk) begin
        if (mem_write) smem[mem_addr] = (corrupt_en && mem_data_in == 8'h3C) ? 8'h3D : mem_data_in;
        rd1 <= !mem_read ? 8'hEE : smem.exists(mem_addr) ? smem[mem_addr] : init_val(mem_addr);
        if (mem_write3) smem3[mem_addr3] = mem_data_in3;
        p30 <= !mem_read3 ? 8'hEE : smem3.exists(mem_addr3) ? smem3[mem_addr3] : init_val(mem_addr3);
        p31 <= p30;
        p32 <= p31;
    end
    assign mem_data_out  = rd1;
    assign mem_data_out3 = p32;

    // Reference model: a command's effect is fixed in issue order, so reads see the latest earlier write.
    task automatic issue(input bit w, input logic [15:0] a, input logic [7:0] d);
        ev_t e;
        e.wr = w; e.rb = 0; e.addr = a; e.data = d;
        acc_cnt++;
        if (w) begin
            rmem[a] = d;
            exp_mem.push_back(e);
`ifdef MEM_MASTER_VERIFY_EN
            e.wr = 0; e.rb = 1;
            exp_mem.push_back(e);
            if (corrupt_en && d == 8'h3C) exp_err++;
`endif
        end else begin
            e.data = rmem.exists(a) ? rmem[a] : init_val(a);
            exp_mem.push_back(e);
            exp_rsp.push_back(e);
        end
    endtask

    ev_t me, mr;
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (mem_read && mem_write) chk("rw_overlap", 32'(mem_read && mem_write), 32'd0);
            if (!cmd_ready) saw_full = 1;
            if (mem_read || mem_write) begin
                if (exp_mem.size() == 0) chk("unexpected_strobe", 32'(mem_addr), 32'hDEAD_0000);
                else begin
                    me = exp_mem.pop_front();
                    chk("strobe_kind", 32'(mem_write), 32'(me.wr));
                    chk("strobe_addr", 32'(mem_addr), 32'(me.addr));
                    if (me.wr) begin
                        chk("wr_data", 32'(mem_data_in), 32'(me.data));
                        wr_cyc.push_back(cyc);
                    end
                    if (!me.rb) pop_cnt++;
                    if (!me.wr && !me.rb) lat_q.push_back(cyc);
                end
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) chk("unexpected_rsp", 32'(rsp_addr), 32'hDEAD_0001);
                else begin
                    mr = exp_rsp.pop_front();
                    chk("rsp_addr", 32'(rsp_addr), 32'(mr.addr));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(mr.data));
                    if (lat_q.size() > 0) chk("rsp_latency", 32'(cyc - lat_q.pop_front()), 32'(LAT1 + 2));
                end
            end
            chk("cmd_ready", 32'(cmd_ready), 32'((acc_cnt - pop_cnt) < DEPTH));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read3 && mem_write3) ov3++;
            if (mem_read3) rd3_cyc = cyc;
            if (mem_write3) begin wa3 = mem_addr3; wd3 = mem_data_in3; end
            if (rsp_valid3) begin n_rsp3++; lat3 = cyc - rd3_cyc; ra3 = rsp_addr3; rdv3 = rsp_rdata3; end
        end
    end

    // Called at posedge+1; holds the command until a sampled cmd_ready, returns at posedge+1.
    task automatic send(input bit w, input logic [15:0] a, input logic [7:0] d);
        bit ok = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
            if (ok) issue(w, a, d);
        end
        cmd_valid = 0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 500 && (busy || exp_mem.size() != 0 || exp_rsp.size() != 0)) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(n < 500), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    bit          w;
    int          r;
    logic [15:0] a;
    initial begin
        rst_n = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        cmd_valid3 = 0; cmd_write3 = 0; cmd_addr3 = '0; cmd_wdata3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data_in", 32'(mem_data_in), 32'd0);
        chk("rst_rsp_addr", 32'(rsp_addr), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1;
        mon_en = 1;
        @(posedge clk);
        #1;
        // Write then read back one location.
        send(1, 16'h0010, 8'hA5);
        send(0, 16'h0010, 8'h00);
        wait_idle();
        chk("wr_rd_rsp_data", 32'(rsp_rdata), 32'hA5);
        chk("wr_rd_rsp_addr", 32'(rsp_addr), 32'h0010);
        // Three consecutive writes.
        wr_cyc.delete();
        send(1, 16'h0020, 8'h11);
        send(1, 16'h0021, 8'h22);
        send(1, 16'h0022, 8'h33);
        wait_idle();
        chk("b2b_count", 32'(wr_cyc.size()), 32'd3);
`ifndef MEM_MASTER_VERIFY_EN
        if (wr_cyc.size() == 3) begin
            chk("b2b_gap1", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
            chk("b2b_gap2", 32'(wr_cyc[2] - wr_cyc[1]), 32'd1);
        end
`endif
        // Reads in front stall the FIFO so the writes behind them fill it.
        saw_full = 0;
        for (int i = 0; i < 4; i++) send(0, 16'h0020 + 16'(i), 8'h00);
        for (int i = 0; i < 5; i++) send(1, 16'h0030 + 16'(i), 8'h40 + 8'(i));
        wait_idle();
        chk("fifo_full_seen", 32'(saw_full), 32'd1);
        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 17));
            a = (r == 16) ? 16'h0000 : (r == 17) ? 16'hFFFF : 16'h0100 + 16'(r);
            send(w, a, 8'($urandom));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_idle();
`ifdef MEM_MASTER_VERIFY_EN
        corrupt_en = 1;
        send(1, 16'h0050, 8'h3C);
        wait_idle();
        corrupt_en = 0;
        chk("corrupt_err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        // Reset while the read is in WAIT.
        send(0, 16'h0123, 8'h00);
        for (int n = 0; n < 20 && !mem_read; n++) @(negedge clk);
        chk("mid_rst_read_seen", 32'(mem_read), 32'd1);
        @(posedge clk);
        #1;
        mon_en = 0;
        rst_n = 0;
        #1;
        chk("mid_rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1;
        exp_mem.delete(); exp_rsp.delete(); lat_q.delete();
        acc_cnt = 0; pop_cnt = 0; exp_err = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({mem_read, mem_write, rsp_valid, busy}), 32'd0);
        end
        mon_en = 1;
        @(posedge clk);
        #1;
        // RD_LAT=3 instance: write then read 0x00FF.
        cmd_valid3 = 1; cmd_write3 = 1; cmd_addr3 = 16'h00FF; cmd_wdata3 = 8'h77;
        @(negedge clk);
        chk("d3_ready_wr", 32'(cmd_ready3), 32'd1);
        @(posedge clk);
        #1;
        cmd_write3 = 0;
        @(negedge clk);
        chk("d3_ready_rd", 32'(cmd_ready3), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid3 = 0;
        repeat (30) @(posedge clk);
        #1;
        chk("d3_overlap", 32'(ov3), 32'd0);
        chk("d3_wr_addr", 32'(wa3), 32'h00FF);
        chk("d3_wr_data", 32'(wd3), 32'h77);
        chk("d3_rsp_count", 32'(n_rsp3), 32'd1);
        chk("d3_latency", 32'(lat3), 32'd5);
        chk("d3_rsp_addr", 32'(ra3), 32'h00FF);
        chk("d3_rsp_rdata", 32'(rdv3), 32'h77);
        chk("d3_err_cnt", 32'(err_cnt3), 32'd0);
        chk("d3_busy", 32'(busy3), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries; power of two, at least 2.
REQ-004 SHALL have parameter RD_LAT, default 1, cycles from the mem_read strobe to valid mem_data_out; range 1..4.
REQ-005 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: cmd_valid  in  1  command offered.
REQ-008 SHALL have port: cmd_ready  out  1  command FIFO can accept.
REQ-009 SHALL have port: cmd_write  in  1  1=write, 0=read.
REQ-010 SHALL have port: cmd_addr  in  ADDR_W  command address.
REQ-011 SHALL have port: cmd_wdata  in  DATA_W  write data.
REQ-012 SHALL have port: rsp_valid  out  1  one-cycle read-response pulse.
REQ-013 SHALL have port: rsp_addr  out  ADDR_W  address of the response.
REQ-014 SHALL have port: rsp_rdata  out  DATA_W  read data.
REQ-015 SHALL have port: busy  out  1  FIFO non-empty or FSM not IDLE.
REQ-016 SHALL have port: mem_addr  out  ADDR_W  to memory slave.
REQ-017 SHALL have port: mem_data_in  out  DATA_W  write data to memory slave.
REQ-018 SHALL have port: mem_data_out  in  DATA_W  read data from memory slave.
REQ-019 SHALL have ports: mem_read and mem_write  out  1  each, memory strobes.
REQ-020 SHALL have port: err_cnt  out  8  readback mismatch count.

Function
REQ-021 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1; cmd_ready = FIFO not full; a same-cycle pop does not raise cmd_ready.
REQ-022 SHALL run FSM states IDLE, WR, RD, WAIT, with CHK added under the macro; IDLE->WR or IDLE->RD when FIFO non-empty, popping the head.
REQ-023 SHALL drive mem_write=1 for exactly the one WR cycle, with mem_addr and mem_data_in registered; a command accepted at edge N gives mem_write high in cycle N+1 at earliest.
REQ-024 SHALL return from WR to WR or RD directly when the FIFO is non-empty, giving back-to-back writes at one per cycle.
REQ-025 SHALL drive mem_read=1 for the single RD cycle, then WAIT, sampling mem_data_out RD_LAT cycles after the strobe cycle.
REQ-026 SHALL pulse rsp_valid for one cycle in the cycle after sampling, with rsp_addr and rsp_rdata held until the next response.
REQ-027 SHALL never assert mem_read and mem_write in the same cycle; mem_addr holds its last value while idle.
REQ-028 SHALL preserve command order; the FIFO pointer wraps at FIFO_DEPTH.

Reset
REQ-029 SHALL on rst_n low, asynchronously: FSM=IDLE, FIFO empty, cmd_ready=1, and busy, rsp_valid, mem_read, mem_write, err_cnt, all addr and data outputs = 0.
REQ-030 SHALL abandon an in-flight command on reset mid-operation, with no response and no strobe in the cycle after release.

Configuration
REQ-031 SHALL, with MEM_MASTER_VERIFY_EN defined, follow each WR with an internal readback: RD, then WAIT, then CHK, comparing against the written data; a mismatch increments err_cnt, saturating at 255; readbacks produce no rsp_valid.
REQ-032 SHALL, without MEM_MASTER_VERIFY_EN, have no CHK state and tie err_cnt to 0.

Structure
REQ-033 SHALL place the FSM state enum and the default width constants in package mem_master_pkg.
REQ-034 SHALL implement the command FIFO as sub-module mem_master_fifo, with push, pop, full, empty and data signals.

Verification
REQ-035 SHALL cover: write 0x0010/0xA5, then read 0x0010, with RD_LAT=1 -> mem_write pulse with addr 0x0010 and data 0xA5, then rsp_valid with rsp_rdata 0xA5 and rsp_addr 0x0010.
REQ-036 SHALL cover: 4 writes offered back-to-back with the memory stalled by continuous reads, FIFO_DEPTH=4 -> cmd_ready low after the 4th acceptance and the 5th held off until a pop.
REQ-037 SHALL cover: 3 consecutive writes -> 3 mem_write pulses in 3 consecutive cycles, with addresses in order.
REQ-038 SHALL cover: rst_n dropped during WAIT -> all strobes 0 immediately, no rsp_valid, and busy 0 after release.
REQ-039 SHALL cover: with MEM_MASTER_VERIFY_EN defined and the memory model corrupting bit 0 on write 0x3C -> err_cnt 1 and no rsp_valid.
REQ-040 SHALL cover: RD_LAT=3, read 0x00FF -> rsp_valid 5 cycles after mem_read and never any read/write overlap.
